axil_fifo_bridge: RTL and testbench



---
 rtl/axil_fifo_bridge_if.sv | 32 +++
 rtl/axil_fifo_bridge.sv | 191 +++++++++++++++++++
 tb/tb_axil_fifo_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_fifo_bridge_if.sv
// AXI4-Lite channel bundle between the core-side master and the FIFO bridge slave.
// Address and data fields are RSIZE bits wide.
interface axil_fifo_bridge_if #(
  parameter int RSIZE = 16
) ();
  logic [RSIZE-1:0] awaddr;
  logic             awvalid;
  logic             awready;
  logic [RSIZE-1:0] wdata;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic [RSIZE-1:0] araddr;
  logic             arvalid;
  logic             arready;
  logic [RSIZE-1:0] rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_fifo_bridge.sv
// AXI4-Lite slave fronting a circular FIFO: a completed write pushes {wdata, awaddr},
// a read pops one entry and returns its data field; occupancy/full/empty/error are exported.
module axil_fifo_bridge #(
  parameter int ADDRSIZE = 5,
  parameter int MSB_SLOT = 5
) (
  input  logic                clk,
  input  logic                reset,
  axil_fifo_bridge_if.slave   axi,
  output logic                full_o,
  output logic                empty_o,
  output logic [ADDRSIZE:0]   ocup_o,
  output logic                error_o
);
  localparam int DEPTH = 2 ** ADDRSIZE;
  localparam int DSIZE = 2 ** MSB_SLOT;
  localparam int RSIZE = DSIZE / 2;
  localparam int CW    = ADDRSIZE + 1;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

  logic [DSIZE-1:0]    mem_q [DEPTH];

  logic                aw_held_q, aw_held_d;
  logic [RSIZE-1:0]    awaddr_h_q, awaddr_h_d;
  logic                w_held_q, w_held_d;
  logic [RSIZE-1:0]    wdata_h_q, wdata_h_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [RSIZE-1:0]    rdata_q, rdata_d;
  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                error_q, error_d;

  logic                aw_fire_s;
  logic                w_fire_s;
  logic                ar_fire_s;
  logic                push_req_s;
  logic                push_ok_s;
  logic                pop_ok_s;
  logic [DSIZE-1:0]    head_s;
  logic                unused_s;

  // Readies depend only on registered state, forced low while reset is asserted.
  assign axi.awready = !aw_held_q && !bvalid_q && !reset;
  assign axi.wready  = !w_held_q  && !bvalid_q && !reset;
  assign axi.arready = !rvalid_q  && !reset;

  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign ocup_o      = cnt_q;
  assign error_o     = error_q;

  assign aw_fire_s  = axi.awvalid && axi.awready;
  assign w_fire_s   = axi.wvalid  && axi.wready;
  assign ar_fire_s  = axi.arvalid && axi.arready;
  assign push_req_s = aw_held_q && w_held_q && !bvalid_q;
  assign head_s     = mem_q[rptr_q];
  // araddr and the address half of the head entry are intentionally never returned.
  assign unused_s   = ^{axi.araddr, head_s[RSIZE-1:0]};

  // Next-state logic for write holds, B channel, R channel, pointers and status.
  always_comb begin
    aw_held_d  = aw_held_q;
    awaddr_h_d = awaddr_h_q;
    w_held_d   = w_held_q;
    wdata_h_d  = wdata_h_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    push_ok_s  = 1'b0;
    pop_ok_s   = 1'b0;

    if (push_req_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (cnt_q != DEPTH_C) begin
        push_ok_s = 1'b1;
        bresp_d   = RESP_OKAY;
        wptr_d    = wptr_q + ADDRSIZE'(1);
      end else begin
        bresp_d   = RESP_SLVERR;
      end
    end else if (bvalid_q && axi.bready) begin
      bvalid_d = 1'b0;
    end else begin
      if (aw_fire_s) begin
        aw_held_d  = 1'b1;
        awaddr_h_d = axi.awaddr;
      end else begin
        aw_held_d  = aw_held_q;
      end
      if (w_fire_s) begin
        w_held_d  = 1'b1;
        wdata_h_d = axi.wdata;
      end else begin
        w_held_d  = w_held_q;
      end
    end

    // Pop is judged on the count at the start of the cycle, not after a concurrent push.
    if (ar_fire_s) begin
      rvalid_d = 1'b1;
      if (cnt_q != {CW{1'b0}}) begin
        pop_ok_s = 1'b1;
        rdata_d  = head_s[DSIZE-1:RSIZE];
        rresp_d  = RESP_OKAY;
        rptr_d   = rptr_q + ADDRSIZE'(1);
      end else begin
        rdata_d  = {RSIZE{1'b0}};
        rresp_d  = RESP_SLVERR;
      end
    end else if (rvalid_q && axi.rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    error_d = (push_req_s && !push_ok_s) || (ar_fire_s && !pop_ok_s);
    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == {CW{1'b0}});
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held_q  <= 1'b0;
      awaddr_h_q <= {RSIZE{1'b0}};
      w_held_q   <= 1'b0;
      wdata_h_q  <= {RSIZE{1'b0}};
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= {RSIZE{1'b0}};
      wptr_q     <= {ADDRSIZE{1'b0}};
      rptr_q     <= {ADDRSIZE{1'b0}};
      cnt_q      <= {CW{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      aw_held_q  <= aw_held_d;
      awaddr_h_q <= awaddr_h_d;
      w_held_q   <= w_held_d;
      wdata_h_q  <= wdata_h_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      error_q    <= error_d;
    end
  end

  // Storage array; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_q[wptr_q] <= {wdata_h_q, awaddr_h_q};
    end
  end
endmodule

// File: tb/tb_axil_fifo_bridge.sv
// Directed self-checking bench for axil_fifo_bridge: reset, basic write/read, empty/full errors,
// split AW/W, B back-pressure, simultaneous push/pop and pointer wrap.
module tb_axil_fifo_bridge;
  logic       clk;
  logic       reset;
  logic       full_o;
  logic       empty_o;
  logic [5:0] ocup_o;
  logic       error_o;

  int n_checks = 0;
  int n_pass   = 0;

  axil_fifo_bridge_if #(.RSIZE(16)) bus ();

  axil_fifo_bridge #(.ADDRSIZE(5), .MSB_SLOT(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .axi     (bus),
    .full_o  (full_o),
    .empty_o (empty_o),
    .ocup_o  (ocup_o),
    .error_o (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simultaneous AW+W; returns at bvalid, completes the B handshake if bready is high.
  task automatic axi_write(input logic [15:0] a, input logic [15:0] d,
                           output logic [1:0] resp, output logic err);
    int   cyc;
    int   lat;
    logic awd, wd, aw_go, w_go;
    cyc = 0; lat = 0; awd = 1'b0; wd = 1'b0;
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    while (!(awd && wd) && cyc < 20) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      tick(); cyc++;
      if (aw_go) begin awd = 1'b1; bus.awvalid = 1'b0; end
      if (w_go)  begin wd  = 1'b1; bus.wvalid  = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_eq("aw_w_accept_cycles", cyc, 1);
    while (!bus.bvalid && lat < 20) begin tick(); lat++; end
    check_eq("b_latency", lat, 1);
    resp = bus.bresp;
    err  = error_o;
    if (bus.bready) tick();
  endtask

  // AR handshake; response is visible right after the accepting edge.
  task automatic axi_read(output logic [15:0] d, output logic [1:0] resp, output logic err);
    int   cyc;
    logic go;
    cyc = 0; go = 1'b0;
    bus.araddr = 16'h0000; bus.arvalid = 1'b1;
    while (!go && cyc < 20) begin
      go = bus.arvalid && bus.arready;
      tick(); cyc++;
    end
    bus.arvalid = 1'b0;
    check_eq("ar_accept_cycles", cyc, 1);
    check_eq("rvalid_after_ar", bus.rvalid, 1'b1);
    d = bus.rdata; resp = bus.rresp; err = error_o;
    if (bus.rready) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [1:0]  r;
    logic        e;

    reset = 1'b1;
    bus.awaddr = 16'h0000; bus.awvalid = 1'b0; bus.wdata = 16'h0000; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = 16'h0000; bus.arvalid = 1'b0; bus.rready = 1'b1;
    tick(); tick();
    check_eq("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check_eq("rst_outputs", {bus.bvalid, bus.bresp, bus.rvalid, bus.rresp, bus.rdata, error_o},
             {1'b0, 2'b00, 1'b0, 2'b00, 16'h0000, 1'b0});
    check_eq("rst_status", {ocup_o, empty_o, full_o}, {6'd0, 1'b1, 1'b0});
    reset = 1'b0;
    tick();
    check_eq("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // Basic write then read
    axi_write(16'h0010, 16'hBEEF, r, e);
    check_eq("w1_bresp", r, 2'b00);
    check_eq("w1_err", e, 1'b0);
    check_eq("w1_ocup", ocup_o, 6'd1);
    check_eq("w1_empty", empty_o, 1'b0);
    axi_read(d, r, e);
    check_eq("r1_data", d, 16'hBEEF);
    check_eq("r1_resp", r, 2'b00);
    check_eq("r1_ocup_empty", {ocup_o, empty_o}, {6'd0, 1'b1});

    // Read while empty
    axi_read(d, r, e);
    check_eq("re_resp", r, 2'b10);
    check_eq("re_data", d, 16'h0000);
    check_eq("re_err", e, 1'b1);
    check_eq("re_err_cleared", error_o, 1'b0);
    check_eq("re_ocup", ocup_o, 6'd0);

    // Fill to full, overflow, then drain in order
    for (int i = 0; i < 32; i++) begin
      axi_write(16'(i + 16'h0100), 16'(i), r, e);
      check_eq("fill_bresp", r, 2'b00);
    end
    check_eq("full_status", {full_o, ocup_o}, {1'b1, 6'd32});
    axi_write(16'h0FFF, 16'hDEAD, r, e);
    check_eq("ovf_bresp", r, 2'b10);
    check_eq("ovf_err", e, 1'b1);
    check_eq("ovf_err_cleared", error_o, 1'b0);
    check_eq("ovf_ocup", ocup_o, 6'd32);
    for (int i = 0; i < 32; i++) begin
      axi_read(d, r, e);
      check_eq("drain_data", d, 16'(i));
    end
    check_eq("drain_empty", {empty_o, full_o, ocup_o}, {1'b1, 1'b0, 6'd0});

    // AW three cycles ahead of W
    bus.awaddr = 16'h0044; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check_eq("split_ready", {bus.awready, bus.wready}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("split_nopush", {bus.bvalid, ocup_o}, {1'b0, 6'd0});
    end
    bus.wdata = 16'h1234; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check_eq("split_b_not_yet", bus.bvalid, 1'b0);
    tick();
    check_eq("split_b", {bus.bvalid, bus.bresp, ocup_o}, {1'b1, 2'b00, 6'd1});
    tick();
    axi_read(d, r, e);
    check_eq("split_data", d, 16'h1234);

    // B back-pressure
    bus.bready = 1'b0;
    axi_write(16'h0050, 16'h5555, r, e);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_hold", {bus.bvalid, bus.bresp, bus.awready, bus.wready}, 5'b1_00_00);
    end
    bus.bready = 1'b1;
    tick();
    check_eq("bp_release", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
    axi_write(16'h0051, 16'h6666, r, e);
    check_eq("bp_next_bresp", r, 2'b00);
    check_eq("bp_ocup", ocup_o, 6'd2);
    axi_read(d, r, e);
    check_eq("bp_rd0", d, 16'h5555);
    axi_read(d, r, e);
    check_eq("bp_rd1", d, 16'h6666);

    // Simultaneous push and pop at ocup=5
    for (int i = 0; i < 5; i++) axi_write(16'h0000, 16'(100 + i), r, e);
    bus.awaddr = 16'h0077; bus.wdata = 16'd200; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check_eq("sim_b", {bus.bvalid, bus.bresp}, 3'b1_00);
    check_eq("sim_r", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, 2'b00, 16'd100});
    check_eq("sim_ocup", ocup_o, 6'd5);
    tick();
    for (int i = 1; i < 5; i++) begin
      axi_read(d, r, e);
      check_eq("sim_drain", d, 16'(100 + i));
    end
    axi_read(d, r, e);
    check_eq("sim_drain_last", d, 16'd200);

    // Pointer wrap with interleaved traffic
    for (int i = 0; i < 40; i++) begin
      axi_write(16'(i), 16'(16'h1000 + i), r, e);
      if (i >= 4) begin
        axi_read(d, r, e);
        check_eq("wrap_data", d, 16'(16'h1000 + i - 4));
      end
    end
    for (int i = 36; i < 40; i++) begin
      axi_read(d, r, e);
      check_eq("wrap_tail", d, 16'(16'h1000 + i));
    end
    check_eq("wrap_empty", {empty_o, ocup_o}, {1'b1, 6'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
